// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the post-reset pulse generator.
// Holds the FSM state encoding, trig_cnt saturation value and a saturating increment.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        S_RST,
        S_COUNT,
        S_PULSE,
        S_DONE
    } pg_state_t;

    localparam int PG_CNT_SAT = 255;

    function automatic logic [7:0] sat_inc(
        input logic [7:0] v,
        input logic [7:0] lim
    );
        return (v >= lim) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_gen_counter.sv
// Load/enable down-counter with a zero flag; stops at zero instead of wrapping.
// Ports: clk, rst (sync, active-high), i_load/i_load_val, i_en, o_zero.
module pulse_gen_counter
    import pulse_gen_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/post_reset_pulse_gen.sv
// Drives a clean PULSE_LEN-cycle pulse on a, d cycles after reset release or a retrigger.
// Ports: clk, rst (sync, active-high), delay, trig in; a, busy, done, trig_cnt out.
// Optional macro PULSE_GEN_ASSERT_EN embeds concurrent timing assertions.
module post_reset_pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int DLY_W     = 4,
    parameter int PULSE_LEN = 1,
    parameter int MAX_TRIG  = PG_CNT_SAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DLY_W-1:0] delay,
    input  logic             trig,
    output logic             a,
    output logic             busy,
    output logic             done,
    output logic [7:0]       trig_cnt
);

    // One extra bit so the largest delay never wraps.
    localparam int CW = DLY_W + 1;
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    pg_state_t    r_state;
    pg_state_t    w_state_nxt;
    logic         r_rst_q;
    logic         r_a;
    logic         w_a_nxt;
    logic [7:0]   r_trig_cnt;
    logic         w_launch;
    logic [CW-1:0] w_d;
    logic [CW-1:0] w_dly_val;
    logic         w_dly_load;
    logic         w_dly_en;
    logic         w_dly_zero;
    logic         w_pls_load;
    logic         w_pls_en;
    logic         w_pls_zero;

    // delay==0 is treated as 1.
    assign w_d = (delay == '0) ? CW'(1) : {1'b0, delay};
    // a is set at edge d-1, so the COUNT phase lasts d-1 edges.
    assign w_dly_val = w_d - CW'(2);

    pulse_gen_counter #(.W(CW)) u_dly_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_dly_load),
        .i_load_val (w_dly_val),
        .i_en       (w_dly_en),
        .o_zero     (w_dly_zero)
    );

    pulse_gen_counter #(.W(PW)) u_pls_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pls_load),
        .i_load_val (PW'(PULSE_LEN - 1)),
        .i_en       (w_pls_en),
        .o_zero     (w_pls_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_launch    = 1'b0;
        w_dly_load  = 1'b0;
        w_dly_en    = 1'b0;
        w_pls_load  = 1'b0;
        w_pls_en    = 1'b0;
        unique case (r_state)
            S_RST: begin
                if (r_rst_q && !rst) begin
                    w_launch = 1'b1;
                end
            end
            S_COUNT: begin
                if (w_dly_zero) begin
                    w_state_nxt = S_PULSE;
                    w_a_nxt     = 1'b1;
                    w_pls_load  = 1'b1;
                end else begin
                    w_dly_en = 1'b1;
                end
            end
            S_PULSE: begin
                if (w_pls_zero) begin
                    w_state_nxt = S_DONE;
                    w_a_nxt     = 1'b0;
                end else begin
                    w_pls_en = 1'b1;
                end
            end
            S_DONE: begin
                if (trig) begin
                    w_launch = 1'b1;
                end
            end
        endcase
        if (w_launch) begin
            if (w_d == CW'(1)) begin
                w_state_nxt = S_PULSE;
                w_a_nxt     = 1'b1;
                w_pls_load  = 1'b1;
            end else begin
                w_state_nxt = S_COUNT;
                w_dly_load  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
        if (rst) begin
            r_state    <= S_RST;
            r_a        <= 1'b0;
            r_trig_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            if (w_a_nxt && !r_a) begin
                r_trig_cnt <= sat_inc(r_trig_cnt, 8'(MAX_TRIG));
            end
        end
    end

    assign a        = r_a;
    assign busy     = (r_state == S_COUNT) || (r_state == S_PULSE);
    assign done     = (r_state == S_DONE);
    assign trig_cnt = r_trig_cnt;

`ifdef PULSE_GEN_ASSERT_EN
    // Cycles remaining until a must rise; equals 1 on the edge where it rises.
    logic [CW-1:0] r_chk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk <= '0;
        end else if (w_launch) begin
            r_chk <= w_d;
        end else if (r_chk != '0) begin
            r_chk <= r_chk - CW'(1);
        end
    end

    a_rise_at_d: assert property (
        @(posedge clk) disable iff (rst)
        (r_chk == CW'(1)) |-> $rose(a)
    ) else $error("a did not rise d cycles after launch at %0t", $time);

    a_pulse_len: assert property (
        @(posedge clk) disable iff (rst)
        $rose(a) |-> a [*PULSE_LEN] ##1 !a
    ) else $error("a pulse length wrong at %0t", $time);

    a_implies_busy: assert property (
        @(posedge clk) disable iff (rst)
        a |-> busy
    ) else $error("a high while not busy at %0t", $time);
`endif

endmodule

// File: tb/tb_post_reset_pulse_gen.sv
// Randomised and directed bench for post_reset_pulse_gen (PULSE_LEN 1 and 3).
// A cycle-offset reference model predicts a, busy, done and trig_cnt each edge.
module tb_post_reset_pulse_gen;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       delay = 4'd1;
    logic             trig = 1'b0;
    logic [1:0]       a_o;
    logic [1:0]       busy_o;
    logic [1:0]       done_o;
    logic [1:0][7:0]  cnt_o;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state, one entry per DUT.
    int n = 0;
    bit m_prev_rst = 1'b0;
    bit m_act [2];
    int m_l   [2];
    int m_d   [2];
    int m_cnt [2];

    always #5 clk = ~clk;

    post_reset_pulse_gen #(.DLY_W(4), .PULSE_LEN(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .delay    (delay),
        .trig     (trig),
        .a        (a_o[0]),
        .busy     (busy_o[0]),
        .done     (done_o[0]),
        .trig_cnt (cnt_o[0])
    );

    post_reset_pulse_gen #(.DLY_W(4), .PULSE_LEN(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .delay    (delay),
        .trig     (trig),
        .a        (a_o[1]),
        .busy     (busy_o[1]),
        .done     (done_o[1]),
        .trig_cnt (cnt_o[1])
    );

    function automatic int plen(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, n, obs, exp);
        end
    endtask

    // Drive inputs, take one edge, advance the model, check #1 later.
    task automatic step(input bit r, input bit t, input int dl);
        bit dn;
        int k;
        int p;
        rst   = r;
        trig  = t;
        delay = dl[3:0];
        @(posedge clk);
        n++;
        for (int i = 0; i < 2; i++) begin
            p = plen(i);
            if (r) begin
                m_act[i] = 1'b0;
                m_cnt[i] = 0;
            end else begin
                dn = m_act[i] && ((n - 1 - m_l[i]) >= (m_d[i] + p - 1));
                if (m_prev_rst || (dn && t)) begin
                    m_act[i] = 1'b1;
                    m_l[i]   = n;
                    m_d[i]   = (dl[3:0] == 0) ? 1 : int'(dl[3:0]);
                end
                if (m_act[i] && (n - m_l[i]) == m_d[i] - 1) begin
                    m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
                end
            end
        end
        m_prev_rst = r;
        #1;
        for (int i = 0; i < 2; i++) begin
            p = plen(i);
            k = n - m_l[i];
            chk($sformatf("a[P%0d]", p), int'(a_o[i]),
                int'(m_act[i] && k >= m_d[i] - 1 && k <= m_d[i] + p - 2));
            chk($sformatf("busy[P%0d]", p), int'(busy_o[i]),
                int'(m_act[i] && k <= m_d[i] + p - 2));
            chk($sformatf("done[P%0d]", p), int'(done_o[i]),
                int'(m_act[i] && k >= m_d[i] + p - 1));
            chk($sformatf("trig_cnt[P%0d]", p), int'(cnt_o[i]), m_cnt[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_l[i]   = 0;
            m_d[i]   = 1;
            m_cnt[i] = 0;
        end

        // delay=1 after 7 reset cycles
        repeat (7) step(1, 0, 1);
        repeat (6) step(0, 0, 1);

        // delay=2 after random reset length
        repeat ($urandom_range(5, 10)) step(1, 0, 2);
        repeat (7) step(0, 0, 2);

        // delay=0 behaves as 1
        repeat (2) step(1, 0, 0);
        repeat (6) step(0, 0, 0);

        // delay=15, delay input scrambled after cycle 0
        repeat (2) step(1, 0, 15);
        step(0, 0, 15);
        repeat (20) step(0, 0, int'($urandom_range(0, 15)));

        // delay=4
        repeat (2) step(1, 0, 4);
        repeat (10) step(0, 0, 4);

        // reset reasserted at cycle 2 of delay=5, then rerelease with 3
        repeat (2) step(1, 0, 5);
        step(0, 0, 5);
        step(0, 1, 5);
        repeat (3) step(1, 0, 5);
        repeat (9) step(0, 0, 3);

        // retrigger from DONE with delay=6; trig while counting ignored
        step(0, 1, 6);
        repeat (3) step(0, 0, 6);
        step(0, 1, 6);
        repeat (10) step(0, 0, 6);

        // trig held in reset is not queued
        repeat (3) step(1, 1, 2);
        repeat (6) step(0, 0, 2);

        // random traffic
        repeat (400) begin
            step(($urandom % 40) == 0, ($urandom % 3) == 0,
                 int'($urandom_range(0, 15)));
        end

        // trig_cnt saturation with back-to-back retriggers
        repeat (2) step(1, 0, 1);
        repeat (1100) step(0, 1, int'($urandom_range(0, 1)));
        repeat (3) step(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
